// File: rtl/code_decode_stage_if.sv
// Stream bundle for the code decode stage: the upstream 3-bit code
// handshake and the downstream decoded-result handshake.
interface code_decode_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic [7:0] out_onehot;
    logic       out_default;

    // Producer/consumer side: drives codes in, accepts results.
    modport master (
        output in_valid,
        input  in_ready,
        output in_code,
        input  out_valid,
        output out_ready,
        input  out_code,
        input  out_onehot,
        input  out_default
    );

    // Decode stage side.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_code,
        output out_valid,
        input  out_ready,
        output out_code,
        output out_onehot,
        output out_default
    );
endinterface

// File: rtl/code_decode_stage.sv
// Registered decode stage: turns each accepted 3-bit code into a one-hot
// select (or a default flag for codes outside LEGAL_MASK), buffered by a
// two-entry skid buffer, and tracks default-code hits in a saturating
// counter plus a sticky flag.
module code_decode_stage #(
    parameter logic [7:0] LEGAL_MASK = 8'hEF,
    parameter int         CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    code_decode_stage_if.slave   bus,
    input  logic                 clr,
    output logic [CNT_W-1:0]     dflt_count,
    output logic                 dflt_sticky
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_reg;

    logic [2:0]       out_code_reg;
    logic [7:0]       out_onehot_reg;
    logic             out_default_reg;
    logic [2:0]       skid_code_reg;
    logic [7:0]       skid_onehot_reg;
    logic             skid_default_reg;

    logic [CNT_W-1:0] dflt_count_reg;
    logic             dflt_sticky_reg;

    logic             in_ready_w;
    logic             acc;
    logic             con;
    logic [7:0]       onehot_next;
    logic             default_next;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Handshake flags come straight from the state register, so in_ready
    // has no combinational dependence on out_ready.
    assign in_ready_w = (state_reg != ST_TWO);
    assign acc        = bus.in_valid && in_ready_w;
    assign con        = (state_reg != ST_EMPTY) && bus.out_ready;

    // Per-bit decode: a bit fires only for its own code and only if that
    // code is a legal case item, so illegal codes yield an all-zero vector.
    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
        assign onehot_next[gi] = LEGAL_MASK[gi] && (bus.in_code == 3'(gi));
    end
    assign default_next = !LEGAL_MASK[bus.in_code];

    // Skid-buffer FSM: occupancy state plus output and skid data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_EMPTY;
            out_code_reg     <= 3'd0;
            out_onehot_reg   <= 8'h00;
            out_default_reg  <= 1'b0;
            skid_code_reg    <= 3'd0;
            skid_onehot_reg  <= 8'h00;
            skid_default_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (acc) begin
                        out_code_reg    <= bus.in_code;
                        out_onehot_reg  <= onehot_next;
                        out_default_reg <= default_next;
                        state_reg       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && con) begin
                        // Pass-through: the new entry replaces the consumed one.
                        out_code_reg    <= bus.in_code;
                        out_onehot_reg  <= onehot_next;
                        out_default_reg <= default_next;
                    end else if (acc) begin
                        // Output is stalled, park the new entry in the skid slot.
                        skid_code_reg    <= bus.in_code;
                        skid_onehot_reg  <= onehot_next;
                        skid_default_reg <= default_next;
                        state_reg        <= ST_TWO;
                    end else if (con) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (con) begin
                        out_code_reg    <= skid_code_reg;
                        out_onehot_reg  <= skid_onehot_reg;
                        out_default_reg <= skid_default_reg;
                        state_reg       <= ST_ONE;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    // Default-hit statistics follow codes entering the stage; an accepted
    // default code takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dflt_count_reg  <= '0;
            dflt_sticky_reg <= 1'b0;
        end else if (clr) begin
            dflt_count_reg  <= (acc && default_next) ? CNT_ONE : '0;
            dflt_sticky_reg <= acc && default_next;
        end else if (acc && default_next) begin
            if (dflt_count_reg != CNT_MAX) begin
                dflt_count_reg <= dflt_count_reg + CNT_ONE;
            end
            dflt_sticky_reg <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = (state_reg != ST_EMPTY);
    assign bus.out_code    = out_code_reg;
    assign bus.out_onehot  = out_onehot_reg;
    assign bus.out_default = out_default_reg;
    assign dflt_count      = dflt_count_reg;
    assign dflt_sticky     = dflt_sticky_reg;

endmodule

// File: tb/tb_code_decode_stage.sv
// Directed bench for code_decode_stage: default-mask instance for decode,
// backpressure, clear and reset; a CNT_W=2 instance for saturation; and a
// LEGAL_MASK=8'h01 instance for the alternate mask.
module tb_code_decode_stage;

    logic clk;
    logic rst_n;
    logic clr_a;
    logic clr_b;
    logic clr_c;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [7:0] cnt_c;
    logic sticky_a;
    logic sticky_b;
    logic sticky_c;

    int total;
    int bad;

    code_decode_stage_if if_a ();
    code_decode_stage_if if_b ();
    code_decode_stage_if if_c ();

    code_decode_stage u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_a),
        .clr        (clr_a),
        .dflt_count (cnt_a),
        .dflt_sticky(sticky_a)
    );

    code_decode_stage #(.LEGAL_MASK(8'hEF), .CNT_W(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_b),
        .clr        (clr_b),
        .dflt_count (cnt_b),
        .dflt_sticky(sticky_b)
    );

    code_decode_stage #(.LEGAL_MASK(8'h01), .CNT_W(8)) u_dut_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if_c),
        .clr        (clr_c),
        .dflt_count (cnt_c),
        .dflt_sticky(sticky_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed decode of codes 0..7 under mask 8'hEF.
    logic [7:0] exp_oh [8];
    logic       exp_df [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // One clock on instance A: apply inputs, take the edge, settle.
    task automatic step_a(input logic v, input logic [2:0] c, input logic r, input logic cl);
        if_a.in_valid  = v;
        if_a.in_code   = c;
        if_a.out_ready = r;
        clr_a          = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [2:0] c);
        if_b.in_valid  = v;
        if_b.in_code   = c;
        if_b.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input logic v, input logic [2:0] c);
        if_c.in_valid  = v;
        if_c.in_code   = c;
        if_c.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_oh = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h20, 8'h40, 8'h80};
        exp_df = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        if_a.in_valid = 1'b1; if_a.in_code = 3'd5; if_a.out_ready = 1'b1; clr_a = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_code = 3'd0; if_b.out_ready = 1'b1; clr_b = 1'b0;
        if_c.in_valid = 1'b0; if_c.in_code = 3'd0; if_c.out_ready = 1'b1; clr_c = 1'b0;

        // Reset state (in_valid high is ignored during reset).
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(if_a.out_valid), 0);
        chk("rst_in_ready", 32'(if_a.in_ready), 1);
        chk("rst_out_code", 32'(if_a.out_code), 0);
        chk("rst_onehot", 32'(if_a.out_onehot), 0);
        chk("rst_default", 32'(if_a.out_default), 0);
        chk("rst_count", 32'(cnt_a), 0);
        chk("rst_sticky", 32'(sticky_a), 0);
        if_a.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(negedge clk);
        #0;

        // Decode sweep, 0..7 with out_ready high: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 3'(i), 1'b1, 1'b0);
            chk($sformatf("sweep%0d_valid", i), 32'(if_a.out_valid), 1);
            chk($sformatf("sweep%0d_code", i), 32'(if_a.out_code), 32'(i));
            chk($sformatf("sweep%0d_onehot", i), 32'(if_a.out_onehot), 32'(exp_oh[i]));
            chk($sformatf("sweep%0d_default", i), 32'(if_a.out_default), 32'(exp_df[i]));
            chk($sformatf("sweep%0d_in_ready", i), 32'(if_a.in_ready), 1);
        end
        step_a(1'b0, 3'd0, 1'b1, 1'b0);
        chk("sweep_drain_valid", 32'(if_a.out_valid), 0);
        chk("sweep_count", 32'(cnt_a), 1);
        chk("sweep_sticky", 32'(sticky_a), 1);

        // Backpressure: 1 and 2 fit, 5 is refused.
        step_a(1'b1, 3'd1, 1'b0, 1'b0);
        chk("bp_first_code", 32'(if_a.out_code), 1);
        chk("bp_first_in_ready", 32'(if_a.in_ready), 1);
        step_a(1'b1, 3'd2, 1'b0, 1'b0);
        chk("bp_second_in_ready", 32'(if_a.in_ready), 0);
        chk("bp_second_hold_code", 32'(if_a.out_code), 1);
        step_a(1'b1, 3'd5, 1'b0, 1'b0);
        chk("bp_full_in_ready", 32'(if_a.in_ready), 0);
        chk("bp_stall_code", 32'(if_a.out_code), 1);
        chk("bp_stall_onehot", 32'(if_a.out_onehot), 32'h02);
        chk("bp_stall_valid", 32'(if_a.out_valid), 1);
        step_a(1'b1, 3'd5, 1'b1, 1'b0);
        chk("bp_drain1_code", 32'(if_a.out_code), 2);
        chk("bp_drain1_onehot", 32'(if_a.out_onehot), 32'h04);
        chk("bp_drain1_in_ready", 32'(if_a.in_ready), 1);
        step_a(1'b1, 3'd5, 1'b1, 1'b0);
        chk("bp_drain2_code", 32'(if_a.out_code), 5);
        chk("bp_drain2_onehot", 32'(if_a.out_onehot), 32'h20);
        chk("bp_drain2_valid", 32'(if_a.out_valid), 1);
        step_a(1'b0, 3'd0, 1'b1, 1'b0);
        chk("bp_empty_valid", 32'(if_a.out_valid), 0);
        chk("bp_count_unchanged", 32'(cnt_a), 1);

        // clr colliding with an accepted default code.
        step_a(1'b1, 3'd4, 1'b1, 1'b0);
        chk("clr_pre_count", 32'(cnt_a), 2);
        step_a(1'b1, 3'd4, 1'b1, 1'b1);
        chk("clr_coll_count", 32'(cnt_a), 1);
        chk("clr_coll_sticky", 32'(sticky_a), 1);
        chk("clr_coll_default", 32'(if_a.out_default), 1);
        step_a(1'b0, 3'd0, 1'b1, 1'b1);
        chk("clr_alone_count", 32'(cnt_a), 0);
        chk("clr_alone_sticky", 32'(sticky_a), 0);
        step_a(1'b0, 3'd0, 1'b1, 1'b0);

        // Reset mid-stream with two entries buffered.
        step_a(1'b1, 3'd4, 1'b0, 1'b0);
        step_a(1'b1, 3'd6, 1'b0, 1'b0);
        chk("mid_full_in_ready", 32'(if_a.in_ready), 0);
        chk("mid_full_count", 32'(cnt_a), 1);
        if_a.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(if_a.out_valid), 0);
        chk("mid_rst_in_ready", 32'(if_a.in_ready), 1);
        chk("mid_rst_count", 32'(cnt_a), 0);
        #1 rst_n = 1'b1;
        step_a(1'b0, 3'd0, 1'b1, 1'b0);
        chk("mid_after_no_result", 32'(if_a.out_valid), 0);
        step_a(1'b1, 3'd3, 1'b1, 1'b0);
        chk("mid_next_valid", 32'(if_a.out_valid), 1);
        chk("mid_next_code", 32'(if_a.out_code), 3);
        step_a(1'b0, 3'd0, 1'b1, 1'b0);

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            step_b(1'b1, 3'd4);
            chk($sformatf("sat%0d_count", i), 32'(cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step_b(1'b0, 3'd0);
        chk("sat_hold_count", 32'(cnt_b), 3);
        chk("sat_sticky", 32'(sticky_b), 1);

        // Alternate mask: only code 0 is legal.
        step_c(1'b1, 3'd0);
        chk("alt0_onehot", 32'(if_c.out_onehot), 32'h01);
        chk("alt0_default", 32'(if_c.out_default), 0);
        chk("alt0_count", 32'(cnt_c), 0);
        step_c(1'b1, 3'd7);
        chk("alt7_onehot", 32'(if_c.out_onehot), 0);
        chk("alt7_default", 32'(if_c.out_default), 1);
        chk("alt7_count", 32'(cnt_c), 1);
        step_c(1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_decode_stage.md
# code_decode_stage

Registered decode stage that consumes a stream of 3-bit codes and produces, per code, a one-hot select vector plus a "default" flag for codes outside the legal set. It sits directly downstream of the 3-bit code producer, ahead of the per-code action logic. It moves the code-select `case` decode out of procedural blocks into a flow-controlled pipeline stage. It also keeps a saturating count and a sticky flag of default-branch hits for status reporting.

## Interface
- `LEGAL_MASK`, default 8'hEF: bit i set means code i is a matched case item. The default leaves code 4 unmatched.
- `CNT_W`, default 8: width of the default-hit counter.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  upstream code valid
- `in_ready`  out  1  stage can accept a code
- `in_code`  in  3  code value
- `out_valid`  out  1  decoded result valid
- `out_ready`  in  1  downstream accepts result
- `out_code`  out  3  code carried through
- `out_onehot`  out  8  one-hot of `out_code` if legal, else 0
- `out_default`  out  1  1 when `out_code` is not in `LEGAL_MASK`
- `dflt_count`  out  CNT_W  saturating count of accepted default codes
- `dflt_sticky`  out  1  set on first accepted default code
- `clr`  in  1  synchronous clear of `dflt_count` and `dflt_sticky`

## Operation
- **Input accept:** a code is accepted when `in_valid && in_ready` at a rising edge.
- **Decode, on accept:**
  - `legal = LEGAL_MASK[in_code]`.
  - `onehot = legal ? (8'b1 << in_code) : 8'h00`.
  - `default = !legal`.
  - Exactly one of `onehot != 0` and `default` holds for every code.
- **Output accept:** a result is consumed when `out_valid && out_ready` at a rising edge.
- **Buffering:** two-entry skid buffer (output register plus skid register). Results are delivered strictly in acceptance order, with no loss or duplication.
- **State machine**, where acc = input accepted and con = output consumed:
  - EMPTY: acc → ONE; otherwise stay.
  - ONE: acc && !con → TWO; !acc && con → EMPTY; otherwise stay. When acc && con, the new entry loads the output register.
  - TWO: con → ONE, and the skid entry moves to the output register. `in_ready` = 0, so no accept is possible.
- **Ready/valid decode:** `in_ready = (state != TWO)`, decoded from the state register only; there is no combinational path from `out_ready`. `out_valid = (state != EMPTY)`.
- **Output stability:** while `out_valid && !out_ready`, `out_code`, `out_onehot` and `out_default` hold stable.
- **Counter update:** on accept of a default code, `dflt_count` increments and `dflt_sticky` is set.
  - `dflt_count` saturates at 2^CNT_W−1 and never wraps.
- **clr:** sets `dflt_count` = 0 and `dflt_sticky` = 0.
  - If `clr` coincides with accept of a default code, the accepted code wins: result is `dflt_count` = 1, `dflt_sticky` = 1.
  - `clr` does not affect the data path.
- **Flag timing:** counter and sticky update on input accept, not output consume, so they reflect codes entering the stage.

## Timing
- **Reset (`rst_n` low), asynchronous and immediate:**
  - state = EMPTY, so `out_valid` = 0 and `in_ready` = 1.
  - `out_code` = 0, `out_onehot` = 0, `out_default` = 0.
  - `dflt_count` = 0, `dflt_sticky` = 0.
  - `in_valid` is ignored while `rst_n` is low.
  - Reset mid-operation discards both buffered entries; no result emerges after deassertion.
- **Latency:** one cycle. A code accepted at edge N is presented with `out_valid` = 1 after edge N, when the stage is empty or the output is being consumed.
- **Throughput:** one code per cycle sustained while `out_ready` = 1.
- **Backpressure:** with `out_ready` held low from EMPTY, exactly two codes are accepted, then `in_ready` drops after the second accept edge.
- **Counter readback:** `dflt_count` and `dflt_sticky` are valid the cycle after the accepting edge.

## Test plan
- **Decode sweep:** reset, then send codes 0..7 with `out_ready` = 1. Outputs arrive one cycle later in order:
  - code 3 gives `out_onehot` = 8'h08, `out_default` = 0;
  - code 4 gives `out_onehot` = 8'h00, `out_default` = 1;
  - final state: `dflt_count` = 1, `dflt_sticky` = 1.
- **Backpressure:** `out_ready` = 0, send 1, 2, 5. Only 1 and 2 are accepted, and `in_ready` = 0 after the second.
  - Raise `out_ready`: outputs are 1, 2, then 5, with no gaps beyond one cycle.
  - Outputs hold stable while stalled.
- **Saturation:** CNT_W = 2, send code 4 five times → `dflt_count` = 3, held, no wrap.
- **clr collision:** `dflt_count` = 2; assert `clr` in the same cycle that code 4 is accepted → `dflt_count` = 1, `dflt_sticky` = 1.
  - `clr` alone on the next cycle → 0 and 0.
- **Reset mid-stream:** two entries buffered; pulse `rst_n` low between edges.
  - Immediately: `out_valid` = 0, `in_ready` = 1, count = 0.
  - Next accepted code is the first output.
- **Alternate mask:** `LEGAL_MASK` = 8'h01; send 0 then 7 → 0 gives onehot 8'h01; 7 gives `out_default` = 1, `dflt_count` = 1.
